// File: rtl/uram_accum_ctrl_if.sv
// Signal bundle between uram_accum_ctrl and its surroundings: update stream, clear control,
// status and both URAM ports. The slave modport is the controller's view.
interface uram_accum_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 72
);
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_delta;
  logic              clr_start;
  logic              busy;
  logic              clr_done;
  logic [31:0]       upd_cnt;
  logic [ADDR_W-1:0] uram_addra;
  logic              uram_wea;
  logic [DATA_W-1:0] uram_douta;
  logic [ADDR_W-1:0] uram_addrb;
  logic              uram_web;
  logic [DATA_W-1:0] uram_dinb;

  modport master (
    output upd_valid, upd_addr, upd_delta, clr_start, uram_douta,
    input  upd_ready, busy, clr_done, upd_cnt,
    input  uram_addra, uram_wea, uram_addrb, uram_web, uram_dinb
  );

  modport slave (
    input  upd_valid, upd_addr, upd_delta, clr_start, uram_douta,
    output upd_ready, busy, clr_done, upd_cnt,
    output uram_addra, uram_wea, uram_addrb, uram_web, uram_dinb
  );
endinterface

// File: rtl/uram_accum_ctrl.sv
// Read-modify-write accumulator scheduler for a dual-port URAM: reads on port A, writes sums
// on port B at one update per cycle, with S2/S3 forwarding and a bulk-clear sweep.
module uram_accum_ctrl #(
  parameter int              ADDR_W    = 16,
  parameter int              DATA_W    = 72,
  parameter int              DEPTH     = 40960,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic clk,
  input logic rst_n,
  uram_accum_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t state, state_next;

  logic [ADDR_W-1:0] cnt;
  logic              upd_ready;
  logic              accept;
  logic              clr_wr;
  logic              clr_last;
  logic              enter_clear;

  logic              s1_v, s2_v, s3_v;
  logic [ADDR_W-1:0] s1_addr, s2_addr, s3_addr;
  logic [DATA_W-1:0] s1_delta, s2_data, s3_data;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] sum;

  logic        clr_done;
  logic [31:0] upd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    upd_ready  = 1'b0;
    clr_wr     = 1'b0;
    clr_last   = 1'b0;
    case (state)
      IDLE: begin
        upd_ready = ~bus.clr_start;
        if (bus.clr_start) state_next = DRAIN;
      end
      DRAIN: begin
        if (!s1_v && !s2_v) state_next = CLEAR;
      end
      CLEAR: begin
        clr_wr = 1'b1;
        if (cnt == LAST) begin
          clr_last   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept      = bus.upd_valid & upd_ready;
  assign enter_clear = (state == DRAIN) && (state_next == CLEAR);

  // The youngest in-flight write to the same entry wins; S3 covers the read that raced S2's write.
  always_comb begin
    old_val = bus.uram_douta;
    if (s2_v && (s2_addr == s1_addr))      old_val = s2_data;
    else if (s3_v && (s3_addr == s1_addr)) old_val = s3_data;
  end

  assign sum = old_val + s1_delta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_addr  <= '0;
      s1_delta <= '0;
      s2_v     <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
      s3_v     <= 1'b0;
      s3_addr  <= '0;
      s3_data  <= '0;
    end else begin
      s1_v     <= accept;
      s1_addr  <= bus.upd_addr;
      s1_delta <= bus.upd_delta;
      s2_v     <= s1_v;
      s2_addr  <= s1_addr;
      s2_data  <= sum;
      s3_v     <= s2_v & (state != CLEAR);
      s3_addr  <= s2_addr;
      s3_data  <= s2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clr_done <= 1'b0;
      upd_cnt  <= '0;
    end else begin
      if (clr_wr) cnt <= clr_last ? '0 : cnt + 1'b1;
      clr_done <= clr_last;
      if (enter_clear) upd_cnt <= '0;
      else if (s2_v)   upd_cnt <= upd_cnt + 32'd1;
    end
  end

  assign bus.upd_ready  = upd_ready;
  assign bus.busy       = (state != IDLE);
  assign bus.clr_done   = clr_done;
  assign bus.upd_cnt    = upd_cnt;
  assign bus.uram_addra = bus.upd_addr;
  assign bus.uram_wea   = 1'b0;
  assign bus.uram_web   = clr_wr | s2_v;
  assign bus.uram_addrb = clr_wr ? cnt : s2_addr;
  assign bus.uram_dinb  = clr_wr ? CLEAR_VAL : s2_data;

endmodule
